// File: rtl/intersection_phase_arbiter_pkg.sv
// intersection_pkg: light encodings, phase and destination types shared by the intersection arbiter
package intersection_pkg;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_RED    = 3'b100;
    typedef enum logic [3:0] {
        HG  = 4'd0,
        HY  = 4'd1,
        AR1 = 4'd2,
        FG  = 4'd3,
        FY  = 4'd4,
        PW  = 4'd5,
        PC  = 4'd6,
        AR2 = 4'd7
    } phase_t;
    typedef enum logic {FARM = 1'b0, PED = 1'b1} dest_t;
endpackage

// File: rtl/intersection_phase_arbiter_timer.sv
// phase_timer: saturating tick counter; elapsed_o already includes the tick of the current cycle
module phase_timer #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick_i,
    input  logic          clr_i,
    output logic [TW-1:0] elapsed_o
);
    logic [TW-1:0] cnt_q;
    always_comb elapsed_o = (tick_i && cnt_q != '1) ? cnt_q + TW'(1) : cnt_q;
    always_ff @(posedge clk) begin
        if (rst || clr_i) cnt_q <= '0;
        else              cnt_q <= elapsed_o;
    end
endmodule

// File: rtl/intersection_phase_arbiter.sv
// intersection_phase_arbiter: highway/farm phase sequencer sharing the crossing among farm, pedestrian and preempt
module intersection_phase_arbiter
    import intersection_pkg::*;
#(
    parameter int HWY_MIN_GREEN  = 20,
    parameter int FARM_MIN_GREEN = 5,
    parameter int FARM_MAX_GREEN = 15,
    parameter int YELLOW_T       = 3,
    parameter int ALL_RED_T      = 1,
    parameter int WALK_T         = 8,
    parameter int PED_CLR_T      = 4,
    parameter int TW             = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       farm_sensor,
    input  logic       ped_req,
    input  logic       emer_req,
    input  logic       emer_dir,
    output logic [2:0] Highway_Light,
    output logic [2:0] Farm_Light,
    output logic       walk,
    output logic       ped_ack,
    output logic [3:0] phase,
    output logic       emer_active
);
    localparam logic [TW-1:0] T_HMIN = TW'(HWY_MIN_GREEN);
    localparam logic [TW-1:0] T_FMIN = TW'(FARM_MIN_GREEN);
    localparam logic [TW-1:0] T_FMAX = TW'(FARM_MAX_GREEN);
    localparam logic [TW-1:0] T_Y    = TW'(YELLOW_T);
    localparam logic [TW-1:0] T_AR   = TW'(ALL_RED_T);
    localparam logic [TW-1:0] T_WALK = TW'(WALK_T);
    localparam logic [TW-1:0] T_PCLR = TW'(PED_CLR_T);

    phase_t        state_q, state_d;
    dest_t         dest_q, dest_d, rr_q, rr_d, arb;
    logic          ped_pend_q, ped_pend_d, ped_ack_q;
    logic          emer_hwy, emer_farm, both, hy_go, pw_entry;
    logic [TW-1:0] el;

    phase_timer #(.TW(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .tick_i   (tick),
        .clr_i    (state_d != state_q),
        .elapsed_o(el)
    );

    always_comb begin
        emer_hwy  = emer_req & ~emer_dir;
        emer_farm = emer_req & emer_dir;
        both      = farm_sensor & ped_pend_q;
        hy_go     = state_q == HG && (emer_farm || (!emer_hwy && el >= T_HMIN && (farm_sensor || ped_pend_q)));
        arb       = emer_farm ? FARM : both ? rr_q : (ped_pend_q && !farm_sensor) ? PED : FARM;
        // a farm preempt overrides a pedestrian destination until the all-red ends
        dest_d    = hy_go ? arb : (emer_farm && (state_q == HY || state_q == AR1)) ? FARM : dest_q;
        rr_d      = (hy_go && !emer_farm && both) ? dest_t'(~rr_q) : rr_q;
        state_d   = state_q;
        case (state_q)
            HG:      state_d = hy_go ? HY : HG;
            HY:      state_d = el >= T_Y ? AR1 : HY;
            AR1:     state_d = el >= T_AR ? (dest_d == PED ? PW : FG) : AR1;
            FG:      state_d = emer_hwy ? FY : emer_farm ? FG :
                               ((el >= T_FMIN && !farm_sensor) || el >= T_FMAX) ? FY : FG;
            FY:      state_d = el >= T_Y ? AR2 : FY;
            PW:      state_d = (emer_hwy || el >= T_WALK) ? PC : PW;
            PC:      state_d = el >= T_PCLR ? AR2 : PC;
            AR2:     state_d = el >= T_AR ? HG : AR2;
            default: state_d = HG;
        endcase
        pw_entry   = state_d == PW && state_q != PW;
        ped_pend_d = ped_req | (ped_pend_q & ~pw_entry);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HG;
            dest_q     <= FARM;
            rr_q       <= FARM;
            ped_pend_q <= 1'b0;
            ped_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dest_q     <= dest_d;
            rr_q       <= rr_d;
            ped_pend_q <= ped_pend_d;
            ped_ack_q  <= pw_entry;
        end
    end

    always_comb begin
        Highway_Light = state_q == HG ? LIGHT_GREEN : state_q == HY ? LIGHT_YELLOW : LIGHT_RED;
        Farm_Light    = state_q == FG ? LIGHT_GREEN : state_q == FY ? LIGHT_YELLOW : LIGHT_RED;
        walk          = state_q == PW;
        phase         = state_q;
        ped_ack       = ped_ack_q;
        emer_active   = emer_req && (emer_dir ? (state_q inside {HG, HY, AR1, FG})
                                              : !(state_q inside {HY, AR1}));
    end
endmodule

// File: tb/tb_intersection_phase_arbiter.sv
// tb_intersection_phase_arbiter: table-driven phase checks plus hand-written multi-cycle sequences
module tb_intersection_phase_arbiter;
    import intersection_pkg::*;

    logic       clk = 1'b0, rst = 1'b1, tick = 1'b1;
    logic       farm_sensor = 1'b0, ped_req = 1'b0, emer_req = 1'b0, emer_dir = 1'b0;
    logic [2:0] Highway_Light, Farm_Light;
    logic       walk, ped_ack, emer_active;
    logic [3:0] phase;
    int         n_cmp = 0, n_bad = 0;

    intersection_phase_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .farm_sensor  (farm_sensor),
        .ped_req      (ped_req),
        .emer_req     (emer_req),
        .emer_dir     (emer_dir),
        .Highway_Light(Highway_Light),
        .Farm_Light   (Farm_Light),
        .walk         (walk),
        .ped_ack      (ped_ack),
        .phase        (phase),
        .emer_active  (emer_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit     do_rst;
        bit     farm, ped, emer, dir;
        phase_t ph;
        bit     ack, ea;
        int     n;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [2:0] exp_hwy(phase_t p);
        return p == HG ? 3'b001 : p == HY ? 3'b010 : 3'b100;
    endfunction
    function automatic logic [2:0] exp_farm(phase_t p);
        return p == FG ? 3'b001 : p == FY ? 3'b010 : 3'b100;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk("no_conflict", 32'((Highway_Light == 3'b100 || Farm_Light == 3'b100) &&
                               (!walk || (Highway_Light == 3'b100 && Farm_Light == 3'b100))), 32'd1);
    endtask

    task automatic do_reset();
        farm_sensor = 0; ped_req = 0; emer_req = 0; emer_dir = 0; tick = 1;
        rst = 1;
        @(posedge clk);
        #1;
        chk("rst_phase", 32'(phase), 32'(HG));
        chk("rst_hwy", 32'(Highway_Light), 32'h1);
        chk("rst_farm", 32'(Farm_Light), 32'h4);
        chk("rst_walk", 32'(walk), 32'd0);
        chk("rst_ack", 32'(ped_ack), 32'd0);
        chk("rst_emer", 32'(emer_active), 32'd0);
        rst = 0;
    endtask

    task automatic wait_phase(input phase_t p, input int budget, input string name);
        int c = 0;
        while (phase !== 4'(p) && c < budget) begin
            step();
            c++;
        end
        chk(name, 32'(phase), 32'(p));
    endtask

    task automatic add(input bit r, f, p, e, d, input phase_t ph, input bit ack, ea, input int n);
        vec_t v;
        v.do_rst = r; v.farm = f; v.ped = p; v.emer = e; v.dir = d;
        v.ph = ph; v.ack = ack; v.ea = ea; v.n = n;
        tbl.push_back(v);
    endtask

    task automatic rst_row();
        add(1, 0, 0, 0, 0, HG, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // idle: highway green forever
        rst_row();
        add(0, 0, 0, 0, 0, HG, 0, 0, 100);
        // farm held on: full cycle at max green, then reset mid-FG
        rst_row();
        add(0, 1, 0, 0, 0, HG, 0, 0, 19);
        add(0, 1, 0, 0, 0, HY, 0, 0, 3);
        add(0, 1, 0, 0, 0, AR1, 0, 0, 1);
        add(0, 1, 0, 0, 0, FG, 0, 0, 15);
        add(0, 1, 0, 0, 0, FY, 0, 0, 3);
        add(0, 1, 0, 0, 0, AR2, 0, 0, 1);
        add(0, 1, 0, 0, 0, HG, 0, 0, 20);
        add(0, 1, 0, 0, 0, HY, 0, 0, 3);
        add(0, 1, 0, 0, 0, AR1, 0, 0, 1);
        add(0, 1, 0, 0, 0, FG, 0, 0, 4);
        rst_row();
        add(0, 0, 0, 0, 0, HG, 0, 0, 5);
        // farm leaves early: exits at minimum green
        rst_row();
        add(0, 1, 0, 0, 0, HG, 0, 0, 19);
        add(0, 1, 0, 0, 0, HY, 0, 0, 3);
        add(0, 1, 0, 0, 0, AR1, 0, 0, 1);
        add(0, 1, 0, 0, 0, FG, 0, 0, 3);
        add(0, 0, 0, 0, 0, FG, 0, 0, 2);
        add(0, 0, 0, 0, 0, FY, 0, 0, 3);
        add(0, 0, 0, 0, 0, AR2, 0, 0, 1);
        add(0, 0, 0, 0, 0, HG, 0, 0, 3);
        // pedestrian pulse
        rst_row();
        add(0, 0, 1, 0, 0, HG, 0, 0, 1);
        add(0, 0, 0, 0, 0, HG, 0, 0, 18);
        add(0, 0, 0, 0, 0, HY, 0, 0, 3);
        add(0, 0, 0, 0, 0, AR1, 0, 0, 1);
        add(0, 0, 0, 0, 0, PW, 1, 0, 1);
        add(0, 0, 0, 0, 0, PW, 0, 0, 7);
        add(0, 0, 0, 0, 0, PC, 0, 0, 4);
        add(0, 0, 0, 0, 0, AR2, 0, 0, 1);
        add(0, 0, 0, 0, 0, HG, 0, 0, 5);
        // round-robin tie: farm first, pedestrian second
        rst_row();
        add(0, 1, 1, 0, 0, HG, 0, 0, 1);
        add(0, 1, 0, 0, 0, HG, 0, 0, 18);
        add(0, 1, 0, 0, 0, HY, 0, 0, 3);
        add(0, 1, 0, 0, 0, AR1, 0, 0, 1);
        add(0, 1, 0, 0, 0, FG, 0, 0, 15);
        add(0, 1, 0, 0, 0, FY, 0, 0, 3);
        add(0, 1, 0, 0, 0, AR2, 0, 0, 1);
        add(0, 1, 0, 0, 0, HG, 0, 0, 20);
        add(0, 1, 0, 0, 0, HY, 0, 0, 3);
        add(0, 1, 0, 0, 0, AR1, 0, 0, 1);
        add(0, 1, 0, 0, 0, PW, 1, 0, 1);
        add(0, 1, 0, 0, 0, PW, 0, 0, 7);
        add(0, 1, 0, 0, 0, PC, 0, 0, 4);
        add(0, 1, 0, 0, 0, AR2, 0, 0, 1);
        // farm preempt from HG elapsed 3, FG held past max
        rst_row();
        add(0, 0, 0, 0, 0, HG, 0, 0, 3);
        add(0, 0, 0, 1, 1, HY, 0, 1, 3);
        add(0, 0, 0, 1, 1, AR1, 0, 1, 1);
        add(0, 0, 0, 1, 1, FG, 0, 1, 40);
        add(0, 0, 0, 0, 0, FY, 0, 0, 3);
        add(0, 0, 0, 0, 0, AR2, 0, 0, 1);
        add(0, 0, 0, 0, 0, HG, 0, 0, 2);
        // farm preempt overrides pedestrian destination in HY; ped served later
        rst_row();
        add(0, 0, 1, 0, 0, HG, 0, 0, 1);
        add(0, 0, 0, 0, 0, HG, 0, 0, 18);
        add(0, 0, 0, 0, 0, HY, 0, 0, 1);
        add(0, 0, 0, 1, 1, HY, 0, 1, 2);
        add(0, 0, 0, 1, 1, AR1, 0, 1, 1);
        add(0, 0, 0, 1, 1, FG, 0, 1, 3);
        add(0, 0, 0, 0, 0, FG, 0, 0, 2);
        add(0, 0, 0, 0, 0, FY, 0, 0, 3);
        add(0, 0, 0, 0, 0, AR2, 0, 0, 1);
        add(0, 0, 0, 0, 0, HG, 0, 0, 20);
        add(0, 0, 0, 0, 0, HY, 0, 0, 3);
        add(0, 0, 0, 0, 0, AR1, 0, 0, 1);
        add(0, 0, 0, 0, 0, PW, 1, 0, 1);
        // highway preempt cuts walk, HG holds, then resumes on elapsed time
        rst_row();
        add(0, 0, 1, 0, 0, HG, 0, 0, 1);
        add(0, 0, 0, 0, 0, HG, 0, 0, 18);
        add(0, 0, 0, 0, 0, HY, 0, 0, 3);
        add(0, 0, 0, 0, 0, AR1, 0, 0, 1);
        add(0, 0, 0, 0, 0, PW, 1, 0, 1);
        add(0, 0, 0, 0, 0, PW, 0, 0, 2);
        add(0, 0, 0, 1, 0, PC, 0, 1, 4);
        add(0, 0, 0, 1, 0, AR2, 0, 1, 1);
        add(0, 0, 0, 1, 0, HG, 0, 1, 2);
        add(0, 1, 0, 1, 0, HG, 0, 1, 25);
        add(0, 1, 0, 0, 0, HY, 0, 0, 1);

        foreach (tbl[i]) begin
            if (tbl[i].do_rst) do_reset();
            for (int k = 0; k < tbl[i].n; k++) begin
                farm_sensor = tbl[i].farm;
                ped_req     = tbl[i].ped;
                emer_req    = tbl[i].emer;
                emer_dir    = tbl[i].dir;
                step();
                chk($sformatf("row%0d_phase", i), 32'(phase), 32'(tbl[i].ph));
                chk($sformatf("row%0d_hwy", i), 32'(Highway_Light), 32'(exp_hwy(tbl[i].ph)));
                chk($sformatf("row%0d_farm", i), 32'(Farm_Light), 32'(exp_farm(tbl[i].ph)));
                chk($sformatf("row%0d_walk", i), 32'(walk), 32'(tbl[i].ph == PW));
                chk($sformatf("row%0d_ack", i), 32'(ped_ack), 32'(tbl[i].ack));
                chk($sformatf("row%0d_emer", i), 32'(emer_active), 32'(tbl[i].ea));
            end
        end

        // timers freeze without tick
        do_reset();
        farm_sensor = 1;
        wait_phase(HY, 40, "reach_hy");
        tick = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("hy_hold_notick", 32'(phase), 32'(HY));
        end
        tick = 1;
        step();
        chk("hy_tick1", 32'(phase), 32'(HY));
        step();
        chk("hy_tick2", 32'(phase), 32'(HY));
        step();
        chk("hy_to_ar1", 32'(phase), 32'(AR1));

        // button pressed during walk re-arms a later walk
        do_reset();
        ped_req = 1;
        step();
        ped_req = 0;
        wait_phase(PW, 40, "reach_pw");
        chk("ack_first", 32'(ped_ack), 32'd1);
        ped_req = 1;
        step();
        ped_req = 0;
        chk("ack_once", 32'(ped_ack), 32'd0);
        wait_phase(HG, 40, "back_hg");
        wait_phase(PW, 60, "ped_rearm_pw");
        chk("ack_rearm", 32'(ped_ack), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
